// File: rtl/snn_sram_pkg.sv
// Shared types for the synaptic weight SRAM controller: FSM states, op codes, lane sizing.
package snn_sram_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    RD   = 2'd2,
    MOD  = 2'd3
  } state_e;

  localparam logic OP_READ   = 1'b0;
  localparam logic OP_UPDATE = 1'b1;

  // Lane index width; a single-lane word still gets a 1-bit index port.
  function automatic int lane_w(input int data_w, input int weight_w);
    int n;
    n = data_w / weight_w;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snn_weight_rmw_ctrl_sat_add.sv
// Replaces one signed weight lane of a word with the saturated sum lane + delta.
// Purely combinational; other lanes pass through untouched.
module weight_lane_sat_add
  import snn_sram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int WEIGHT_WIDTH = 8,
  localparam int LANE_W      = lane_w(DATA_WIDTH, WEIGHT_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0]   word_i,
  input  logic [LANE_W-1:0]       lane_i,
  input  logic [WEIGHT_WIDTH-1:0] delta_i,
  output logic [DATA_WIDTH-1:0]   word_o,
  output logic                    sat_o
);

  localparam int NLANES = DATA_WIDTH / WEIGHT_WIDTH;

  logic                    hit;
  logic [WEIGHT_WIDTH-1:0] lane_val;
  logic [WEIGHT_WIDTH:0]   sum;
  logic [WEIGHT_WIDTH-1:0] res;
  logic                    ovf;

  always_comb begin
    hit      = 1'b0;
    lane_val = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (lane_i == LANE_W'(i)) begin
        hit      = 1'b1;
        lane_val = word_i[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
    end

    // One guard bit: the sum overflowed exactly when the top two bits differ.
    sum = {lane_val[WEIGHT_WIDTH-1], lane_val} + {delta_i[WEIGHT_WIDTH-1], delta_i};
    ovf = sum[WEIGHT_WIDTH] ^ sum[WEIGHT_WIDTH-1];
    if (ovf) begin
      res = sum[WEIGHT_WIDTH] ? {1'b1, {(WEIGHT_WIDTH-1){1'b0}}}
                              : {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};
    end else begin
      res = sum[WEIGHT_WIDTH-1:0];
    end

    word_o = word_i;
    for (int i = 0; i < NLANES; i++) begin
      if (lane_i == LANE_W'(i)) begin
        word_o[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] = res;
      end
    end
    sat_o = hit & ovf;
  end

endmodule

// File: rtl/snn_weight_rmw_ctrl.sv
// Owns the weight SRAM port: zero-fill sweep after reset, then one read or lane update at a time.
// Accepted at t: SRAM read at t+1, response or write-back at t+2; req_ready low until t+3, no rsp backpressure.
module snn_weight_rmw_ctrl
  import snn_sram_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 8,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    SRAM_DEPTH   = 256,
  parameter int                    WEIGHT_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0,
  localparam int                   LANE_W       = lane_w(DATA_WIDTH, WEIGHT_WIDTH)
) (
  input  logic                    CK,
  input  logic                    RST,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_op,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [LANE_W-1:0]       req_lane,
  input  logic [WEIGHT_WIDTH-1:0] req_delta,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    sat_flag,
  output logic                    init_done,
  output logic                    sram_cs,
  output logic                    sram_we,
  output logic [ADDR_WIDTH-1:0]   sram_a,
  output logic [DATA_WIDTH-1:0]   sram_d,
  input  logic [DATA_WIDTH-1:0]   sram_q
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SRAM_DEPTH - 1);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic                    done_q;
  logic                    op_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LANE_W-1:0]       lane_q;
  logic [WEIGHT_WIDTH-1:0] delta_q;
  logic [DATA_WIDTH-1:0]   rsp_q;

  logic [DATA_WIDTH-1:0]   upd_word;
  logic                    upd_sat;

  weight_lane_sat_add #(
    .DATA_WIDTH   (DATA_WIDTH),
    .WEIGHT_WIDTH (WEIGHT_WIDTH)
  ) u_sat_add (
    .word_i  (sram_q),
    .lane_i  (lane_q),
    .delta_i (delta_q),
    .word_o  (upd_word),
    .sat_o   (upd_sat)
  );

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= INIT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      lane_q  <= '0;
      delta_q <= '0;
      rsp_q   <= '0;
    end else begin
      unique case (state_q)
        INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            lane_q  <= req_lane;
            delta_q <= req_delta;
            state_q <= RD;
          end
        end
        RD: state_q <= MOD;
        MOD: begin
          if (op_q == OP_READ) rsp_q <= sram_q;
          state_q <= IDLE;
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // SRAM side decodes only state and latched request, never req_* directly.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    sat_flag  = 1'b0;
    sram_cs   = 1'b0;
    sram_we   = 1'b0;
    sram_a    = '0;
    sram_d    = '0;
    if (!RST) begin
      unique case (state_q)
        INIT: begin
          sram_cs = 1'b1;
          sram_we = 1'b1;
          sram_a  = cnt_q;
          sram_d  = INIT_VALUE;
        end
        IDLE: req_ready = 1'b1;
        RD: begin
          sram_cs = 1'b1;
          sram_a  = addr_q;
        end
        MOD: begin
          if (op_q == OP_UPDATE) begin
            sram_cs  = 1'b1;
            sram_we  = 1'b1;
            sram_a   = addr_q;
            sram_d   = upd_word;
            sat_flag = upd_sat;
          end else begin
            rsp_valid = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign init_done = done_q & ~RST;
  assign rsp_data  = RST ? '0 : (rsp_valid ? sram_q : rsp_q);

endmodule
